// File: rtl/shift_sequencer.sv
// Multi-cycle sequencer for the shift datapath: drives amount/source mux selects and
// the RegDesloc command for one shift operation, then issues a single write strobe.
module shift_sequencer #(
    parameter int unsigned SHIFT_LAT   = 1,
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [1:0] amt_src,
    input  logic       src_sel,
    input  logic       mem_valid,
    output logic [1:0] shift_amt_sel,
    output logic       shift_src_sel,
    output logic [2:0] shift_ctrl,
    output logic       reg_write,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_WRITE    = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

    localparam logic [3:0] SHIFT_LAST = 4'(SHIFT_LAT - 1);
    localparam logic [7:0] MEM_LAST   = 8'(MEM_TIMEOUT - 1);

    function automatic logic [2:0] shift_cmd(input logic [1:0] op_v);
        logic [2:0] cmd;
        case (op_v)
            2'b00:   cmd = 3'b010;
            2'b01:   cmd = 3'b011;
            2'b10:   cmd = 3'b100;
            default: cmd = 3'b000;
        endcase
        return cmd;
    endfunction

    state_t     state_r, state_s;
    logic [1:0] op_r, op_s;
    logic [1:0] amt_src_r, amt_src_s;
    logic       src_sel_r, src_sel_s;
    logic [7:0] wait_cnt_r, wait_cnt_s;
    logic [3:0] shift_cnt_r, shift_cnt_s;

    logic [1:0] shift_amt_sel_s;
    logic       shift_src_sel_s;
    logic [2:0] shift_ctrl_s;
    logic       reg_write_s;
    logic       busy_s;
    logic       done_s;
    logic       error_s;

    // Next-state, request capture and cycle counters.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        amt_src_s   = amt_src_r;
        src_sel_s   = src_sel_r;
        wait_cnt_s  = wait_cnt_r;
        shift_cnt_s = shift_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_s        = op;
                    amt_src_s   = amt_src;
                    src_sel_s   = src_sel;
                    wait_cnt_s  = 8'd0;
                    shift_cnt_s = 4'd0;
                    if ((op == 2'b11) || (amt_src == 2'b11)) begin
                        state_s = ST_ERR;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (amt_src_r == 2'b10) begin
                    state_s = ST_WAIT_MEM;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_WAIT_MEM: begin
                // mem_valid wins over a timeout landing in the same cycle
                if (mem_valid) begin
                    state_s = ST_SHIFT;
                end else if (wait_cnt_r == MEM_LAST) begin
                    state_s = ST_ERR;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (shift_cnt_r == SHIFT_LAST) begin
                    state_s = ST_WRITE;
                end else begin
                    shift_cnt_s = shift_cnt_r + 4'd1;
                end
            end
            ST_WRITE: state_s = ST_IDLE;
            ST_ERR:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they can be registered without extra latency.
    always_comb begin
        shift_amt_sel_s = 2'b00;
        shift_src_sel_s = 1'b0;
        shift_ctrl_s    = 3'b000;
        if (state_s != ST_IDLE) begin
            shift_amt_sel_s = amt_src_s;
            shift_src_sel_s = src_sel_s;
        end else begin
            shift_amt_sel_s = 2'b00;
            shift_src_sel_s = 1'b0;
        end
        case (state_s)
            ST_LOAD:  shift_ctrl_s = 3'b001;
            ST_SHIFT: shift_ctrl_s = shift_cmd(op_s);
            default:  shift_ctrl_s = 3'b000;
        endcase
        reg_write_s = (state_s == ST_WRITE);
        done_s      = (state_s == ST_WRITE);
        error_s     = (state_s == ST_ERR);
        busy_s      = (state_s == ST_LOAD) || (state_s == ST_WAIT_MEM) ||
                      (state_s == ST_SHIFT) || (state_s == ST_WRITE);
    end

    // State, capture and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_r        <= 2'b00;
            amt_src_r   <= 2'b00;
            src_sel_r   <= 1'b0;
            wait_cnt_r  <= 8'd0;
            shift_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            amt_src_r   <= amt_src_s;
            src_sel_r   <= src_sel_s;
            wait_cnt_r  <= wait_cnt_s;
            shift_cnt_r <= shift_cnt_s;
        end
    end

    // Registered outputs; reset drops every strobe and select at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_amt_sel <= 2'b00;
            shift_src_sel <= 1'b0;
            shift_ctrl    <= 3'b000;
            reg_write     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            shift_amt_sel <= shift_amt_sel_s;
            shift_src_sel <= shift_src_sel_s;
            shift_ctrl    <= shift_ctrl_s;
            reg_write     <= reg_write_s;
            busy          <= busy_s;
            done          <= done_s;
            error         <= error_s;
        end
    end

endmodule
